hex_keypad_entry: RTL and testbench

Scans a 4x4 hex keypad (Digilent PmodKYPD layout), debounces presses and shifts each confirmed hex digit into a 16-bit entry register. It is the input-side counterpart of the board's multiplexed 7-segment display path. `value` feeds the display driver's 16-bit input directly, and `key_valid` is available to control logic. Column strobing is time-multiplexed from a clock divider, mirroring the display's digit multiplexing.

---
 rtl/hex_keypad_entry_pkg.sv | 54 +++++
 rtl/kp_tick_gen.sv | 27 ++
 rtl/hex_keypad_entry.sv | 134 +++++++++++++
 tb/tb_hex_keypad_entry.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_keypad_entry_pkg.sv
// Shared types and helpers for the hex keypad entry block.
// Covers the FSM states, column drive patterns and the PmodKYPD key map.
package hex_keypad_entry_pkg;

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StHeld,
    StReleaseDb
  } state_e;

  localparam logic [3:0] Col0 = 4'b1110;
  localparam logic [3:0] Col1 = 4'b1101;
  localparam logic [3:0] Col2 = 4'b1011;
  localparam logic [3:0] Col3 = 4'b0111;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    drv = Col0;
    unique case (idx)
      2'd0: drv = Col0;
      2'd1: drv = Col1;
      2'd2: drv = Col2;
      2'd3: drv = Col3;
    endcase
    return drv;
  endfunction

  // Row 0 is the top row of the keypad.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    code = 4'h0;
    unique case ({c, r})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hF;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      4'b11_11: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/kp_tick_gen.sv
// Scan tick generator: free-running divider, tick high while the count is SCAN_DIV-1.
module kp_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce; confirmed digits shift into a 16-bit entry register.
// All row decisions are taken on scan ticks from the synchronized row bus.
module hex_keypad_entry
  import hex_keypad_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_N - 1);

  logic        tick;
  logic [3:0]  row_m_q, row_s_q;
  state_e      state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  rsel_q, rsel_d;
  logic [DbW-1:0] db_q, db_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        any_low;
  logic [1:0]  low_idx;

  kp_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) low_idx = 2'(i);
    end
  end

  assign any_low = (row_s_q != 4'hF);

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    rsel_d    = rsel_q;
    db_d      = db_q;
    code_d    = code_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (!any_low) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            rsel_d  = low_idx;
            db_d    = DbW'(1);
            state_d = StPressDb;
          end
        end
        StPressDb: begin
          if (any_low && (low_idx == rsel_q)) begin
            if (db_q == DbLast) begin
              code_d  = key_map(col_idx_q, rsel_q);
              value_d = {value_q[11:0], key_map(col_idx_q, rsel_q)};
              valid_d = 1'b1;
              state_d = StHeld;
            end else begin
              db_d = db_q + 1'b1;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = StScan;
          end
        end
        StHeld: begin
          if (!any_low) begin
            db_d    = DbW'(1);
            state_d = StReleaseDb;
          end
        end
        StReleaseDb: begin
          if (any_low) begin
            state_d = StHeld;
          end else if (db_q == DbLast) begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = StScan;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      row_m_q   <= 4'hF;
      row_s_q   <= 4'hF;
      state_q   <= StScan;
      col_idx_q <= 2'd0;
      rsel_q    <= 2'd0;
      db_q      <= '0;
      code_q    <= 4'h0;
      value_q   <= 16'h0000;
      valid_q   <= 1'b0;
    end else begin
      row_m_q   <= row;
      row_s_q   <= row_m_q;
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      rsel_q    <= rsel_d;
      db_q      <= db_d;
      code_q    <= code_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
    end
  end

  assign col       = col_drive(col_idx_q);
  assign value     = value_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry with a behavioural keypad and entry-register model.
module tb_hex_keypad_entry;

  localparam int ScanDiv = 4;

  // Key legend indexed by col*4 + row.
  localparam logic [3:0] CodeTab [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  row, col, key_code;
  logic [15:0] value;
  logic        key_valid;
  logic [15:0] keys;
  logic [15:0] exp_value;
  logic        prev_valid = 1'b0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          n_pulses = 0;
  int          consec = 0;

  hex_keypad_entry #(
    .SCAN_DIV   (4),
    .DEBOUNCE_N (3)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .row       (row),
    .col       (col),
    .value     (value),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid) begin
      n_pulses++;
      if (prev_valid) consec++;
    end
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * ScanDiv) @(negedge clk);
  endtask

  // Clean press and release of one key, then compare against the model.
  task automatic press(input int c, input int r, input int hold, input int rel, input string tag);
    int p0;
    int nv;
    p0 = n_pulses;
    keys = 16'h0;
    keys[c*4+r] = 1'b1;
    ticks(hold);
    keys = 16'h0;
    ticks(rel);
    nv = (int'(exp_value) * 16 + int'(CodeTab[c*4+r])) % 65536;
    exp_value = 16'(nv);
    check({tag, " pulses"}, 16'(n_pulses - p0), 16'd1);
    check({tag, " key_code"}, {12'h0, key_code}, {12'h0, CodeTab[c*4+r]});
    check({tag, " value"}, value, exp_value);
  endtask

  initial begin
    int p0;
    int found;
    keys = 16'h0;
    clr = 1'b1;
    exp_value = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state and column rotation.
    check("reset col", {12'h0, col}, 16'h000E);
    check("reset value", value, 16'h0000);
    check("reset key_valid", {15'h0, key_valid}, 16'h0000);
    check("reset key_code", {12'h0, key_code}, 16'h0000);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("col before first tick", {12'h0, col}, 16'h000E);
    @(negedge clk);
    check("col step 1", {12'h0, col}, 16'h000D);
    ticks(1);
    check("col step 2", {12'h0, col}, 16'h000B);
    ticks(1);
    check("col step 3", {12'h0, col}, 16'h0007);
    ticks(1);
    check("col wrap", {12'h0, col}, 16'h000E);

    // Single long press of 8: one pulse, column frozen while held.
    p0 = n_pulses;
    keys = 16'h0;
    keys[1*4+2] = 1'b1;
    ticks(30);
    check("hold col frozen", {12'h0, col}, 16'h000D);
    check("hold key_code", {12'h0, key_code}, 16'h0008);
    check("hold value", value, 16'h0008);
    check("hold pulses", 16'(n_pulses - p0), 16'd1);
    keys = 16'h0;
    ticks(10);
    exp_value = 16'h0008;

    // Digit shift 1..5.
    p0 = n_pulses;
    press(0, 0, 14, 10, "digit 1");
    press(1, 0, 14, 10, "digit 2");
    press(2, 0, 14, 10, "digit 3");
    press(0, 1, 14, 10, "digit 4");
    press(1, 1, 14, 10, "digit 5");
    check("shift value", value, 16'h2345);
    check("shift pulses", 16'(n_pulses - p0), 16'd5);

    // Two-tick bounce on key A is rejected and scanning continues.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (col == 4'b0111) found = 1;
    end
    check("bounce reach c3", 16'(found), 16'd1);
    p0 = n_pulses;
    keys = 16'h0;
    keys[3*4+0] = 1'b1;
    ticks(2);
    keys = 16'h0;
    found = 0;
    for (int i = 0; i < 24 && found == 0; i++) begin
      @(negedge clk);
      if (col == 4'b1110) found = 1;
    end
    check("bounce scan resumes", 16'(found), 16'd1);
    ticks(4);
    check("bounce no pulse", 16'(n_pulses - p0), 16'd0);
    check("bounce value kept", value, exp_value);

    // Two keys in c2: top row wins; release glitch yields no second pulse.
    p0 = n_pulses;
    keys = 16'h0;
    keys[2*4+0] = 1'b1;
    keys[2*4+3] = 1'b1;
    ticks(15);
    check("multi key_code", {12'h0, key_code}, 16'h0003);
    keys = 16'h0;
    ticks(1);
    keys[2*4+0] = 1'b1;
    ticks(1);
    keys = 16'h0;
    ticks(10);
    exp_value = {exp_value[11:0], 4'h3};
    check("multi pulses", 16'(n_pulses - p0), 16'd1);
    check("multi value", value, exp_value);

    // Randomized clean presses.
    for (int k = 0; k < 12; k++) begin
      press(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            int'($urandom_range(20, 12)), int'($urandom_range(12, 8)), "random");
    end

    // Reset while holding A, then a fresh entry of F.
    p0 = n_pulses;
    keys = 16'h0;
    keys[3*4+0] = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (n_pulses != p0) found = 1;
    end
    check("midreset press seen", 16'(found), 16'd1);
    check("midreset key_code", {12'h0, key_code}, 16'h000A);
    ticks(2);
    clr = 1'b1;
    #1;
    check("midreset value", value, 16'h0000);
    check("midreset col", {12'h0, col}, 16'h000E);
    check("midreset key_valid", {15'h0, key_valid}, 16'h0000);
    check("midreset key_code clr", {12'h0, key_code}, 16'h0000);
    keys = 16'h0;
    ticks(2);
    clr = 1'b0;
    exp_value = 16'h0000;
    press(1, 3, 15, 10, "after reset F");
    check("after reset value", value, 16'h000F);

    check("no back-to-back pulses", 16'(consec), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
